axi_mem_arbiter: RTL and testbench

Shares the single AXI4 master port of the SoC between the instruction-fetch refill path (I-side, read-only line bursts) and the data-memory path (D-side, single-word read/write). Accepts one request at a time with round-robin arbitration, sequences the AXI address, data and response channels, and returns read beats or completion status to the winning requester. Sits between the processor's cache-miss logic and the external `m00_axi_*` interface. Constant AXI fields (`*id`, `*lock`, `*cache`, `*prot`, `*qos`) are tied off outside this block.

---
 rtl/axi_mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter that shares one AXI4 master port between the I-side line refill
// path and the D-side single-word path, with one AXI transaction in flight at a time.
module axi_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ILINE_BEATS = 4
) (
    input  logic                  m00_axi_aclk,
    input  logic                  m00_axi_aresetn,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rlast,
    output logic                  i_err,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [3:0]            d_wstrb,
    output logic                  d_gnt,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,

    output logic [ADDR_WIDTH-1:0] m00_axi_awaddr,
    output logic [7:0]            m00_axi_awlen,
    output logic [2:0]            m00_axi_awsize,
    output logic [1:0]            m00_axi_awburst,
    output logic                  m00_axi_awvalid,
    input  logic                  m00_axi_awready,
    output logic [DATA_WIDTH-1:0] m00_axi_wdata,
    output logic [3:0]            m00_axi_wstrb,
    output logic                  m00_axi_wlast,
    output logic                  m00_axi_wvalid,
    input  logic                  m00_axi_wready,
    input  logic [1:0]            m00_axi_bresp,
    input  logic                  m00_axi_bvalid,
    output logic                  m00_axi_bready,

    output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [7:0]            m00_axi_arlen,
    output logic [2:0]            m00_axi_arsize,
    output logic [1:0]            m00_axi_arburst,
    output logic                  m00_axi_arvalid,
    input  logic                  m00_axi_arready,
    input  logic [DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rlast,
    input  logic                  m00_axi_rvalid,
    output logic                  m00_axi_rready
);

    localparam int LineLsb = $clog2(ILINE_BEATS * 4);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_e;

    state_e                state_q, state_d;
    logic                  lastD_q;
    logic                  srcD_q;
    logic [ADDR_WIDTH-1:0] araddr_q, awaddr_q;
    logic [7:0]            arlen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;
    logic                  wlast_q;
    logic                  awDone_q, wDone_q;
    logic [7:0]            beatCnt_q;
    logic                  errAcc_q;
    logic                  iRvalid_q, iRlast_q, iErr_q, dDone_q, dErr_q;
    logic [DATA_WIDTH-1:0] iRdata_q, dRdata_q;

    logic                  rHs;
    logic                  beatErr;
    logic                  errNow;
    logic                  unused_bits;

    assign unused_bits = ^{i_addr[LineLsb-1:0], d_addr[1:0], m00_axi_rresp[0], m00_axi_bresp[0]};

    assign m00_axi_awaddr  = awaddr_q;
    assign m00_axi_awlen   = 8'd0;
    assign m00_axi_awsize  = 3'b010;
    assign m00_axi_awburst = 2'b01;
    assign m00_axi_awvalid = (state_q == WADDR) && !awDone_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = wstrb_q;
    assign m00_axi_wlast   = wlast_q;
    assign m00_axi_wvalid  = (state_q == WADDR) && !wDone_q;
    assign m00_axi_bready  = (state_q == WRESP);
    assign m00_axi_araddr  = araddr_q;
    assign m00_axi_arlen   = arlen_q;
    assign m00_axi_arsize  = 3'b010;
    assign m00_axi_arburst = 2'b01;
    assign m00_axi_arvalid = (state_q == RADDR);
    assign m00_axi_rready  = (state_q == RDATA);

    assign i_rvalid = iRvalid_q;
    assign i_rdata  = iRdata_q;
    assign i_rlast  = iRlast_q;
    assign i_err    = iErr_q;
    assign d_done   = dDone_q;
    assign d_rdata  = dRdata_q;
    assign d_err    = dErr_q;

    // A burst is in error if any beat reports SLVERR/DECERR or rlast lands on the wrong beat.
    assign rHs     = (state_q == RDATA) && m00_axi_rvalid;
    assign beatErr = m00_axi_rresp[1] | (m00_axi_rlast & (beatCnt_q != arlen_q));
    assign errNow  = errAcc_q | beatErr;

    always_comb begin
        state_d = state_q;
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (m00_axi_aresetn && d_req && (!i_req || !lastD_q)) begin
                    d_gnt   = 1'b1;
                    state_d = d_we ? WADDR : RADDR;
                end else if (m00_axi_aresetn && i_req) begin
                    i_gnt   = 1'b1;
                    state_d = RADDR;
                end
            end
            RADDR:   if (m00_axi_arready) state_d = RDATA;
            RDATA:   if (m00_axi_rvalid && m00_axi_rlast) state_d = IDLE;
            WADDR: begin
                if ((awDone_q || m00_axi_awready) && (wDone_q || m00_axi_wready)) state_d = WRESP;
            end
            WRESP:   if (m00_axi_bvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q   <= IDLE;
            lastD_q   <= 1'b0;
            srcD_q    <= 1'b0;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            arlen_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wlast_q   <= 1'b0;
            awDone_q  <= 1'b0;
            wDone_q   <= 1'b0;
            beatCnt_q <= '0;
            errAcc_q  <= 1'b0;
            iRvalid_q <= 1'b0;
            iRdata_q  <= '0;
            iRlast_q  <= 1'b0;
            iErr_q    <= 1'b0;
            dDone_q   <= 1'b0;
            dRdata_q  <= '0;
            dErr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            iRvalid_q <= 1'b0;
            iRlast_q  <= 1'b0;
            iErr_q    <= 1'b0;
            dDone_q   <= 1'b0;
            dErr_q    <= 1'b0;

            if (i_gnt || d_gnt) begin
                lastD_q   <= d_gnt;
                srcD_q    <= d_gnt;
                beatCnt_q <= '0;
                errAcc_q  <= 1'b0;
                awDone_q  <= 1'b0;
                wDone_q   <= 1'b0;
                if (i_gnt) begin
                    araddr_q <= {i_addr[ADDR_WIDTH-1:LineLsb], {LineLsb{1'b0}}};
                    arlen_q  <= 8'(ILINE_BEATS - 1);
                    wlast_q  <= 1'b0;
                end else begin
                    araddr_q <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
                    awaddr_q <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
                    arlen_q  <= 8'd0;
                    wdata_q  <= d_wdata;
                    wstrb_q  <= d_wstrb;
                    wlast_q  <= d_we;
                end
            end

            if (state_q == WADDR) begin
                if (m00_axi_awvalid && m00_axi_awready) awDone_q <= 1'b1;
                if (m00_axi_wvalid && m00_axi_wready)   wDone_q  <= 1'b1;
            end

            if (rHs) begin
                beatCnt_q <= beatCnt_q + 8'd1;
                errAcc_q  <= errNow;
                if (!srcD_q) begin
                    iRvalid_q <= 1'b1;
                    iRdata_q  <= m00_axi_rdata;
                    iRlast_q  <= m00_axi_rlast;
                    iErr_q    <= errNow;
                end else if (m00_axi_rlast) begin
                    dDone_q  <= 1'b1;
                    dRdata_q <= m00_axi_rdata;
                    dErr_q   <= errNow;
                end
            end

            if ((state_q == WRESP) && m00_axi_bvalid) begin
                dDone_q <= 1'b1;
                dErr_q  <= m00_axi_bresp[1];
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scoreboard bench for axi_mem_arbiter: a reactive AXI slave model serves bursts while a
// monitor pops expected completions as the DUT emits them.
module tb_axi_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BEATS = 4;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic          iReq = 1'b0, dReq = 1'b0, dWe = 1'b0;
    logic [AW-1:0] iAddr = '0, dAddr = '0;
    logic [DW-1:0] dWdata = '0;
    logic [3:0]    dWstrb = '0;
    logic          iGnt, iRvalid, iRlast, iErr, dGnt, dDone, dErr;
    logic [DW-1:0] iRdata, dRdata;

    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst;
    logic          awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    axi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ILINE_BEATS(BEATS)) dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rstN),
        .i_req(iReq), .i_addr(iAddr), .i_gnt(iGnt), .i_rvalid(iRvalid), .i_rdata(iRdata),
        .i_rlast(iRlast), .i_err(iErr),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_wstrb(dWstrb),
        .d_gnt(dGnt), .d_done(dDone), .d_rdata(dRdata), .d_err(dErr),
        .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen), .m00_axi_awsize(awsize),
        .m00_axi_awburst(awburst), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
        .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
        .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
        .m00_axi_araddr(araddr), .m00_axi_arlen(arlen), .m00_axi_arsize(arsize),
        .m00_axi_arburst(arburst), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rlast(rlast),
        .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
    );

    typedef struct {
        logic        isD;
        logic        chkData;
        logic [31:0] data;
        logic        last;
        logic        err;
    } expItem_t;

    expItem_t expQ[$];
    logic     gntLog[$];
    int       totalChecks = 0;
    int       badChecks   = 0;

    logic [31:0] cfgBase    = '0;
    int          cfgShortAt = -1;
    int          cfgWDelay  = 0;
    logic [1:0]  cfgBresp   = 2'b00;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, observed, expected);
        end
    endtask

    // Pushes the expected completions, then raises the request until its grant is seen.
    task automatic applyStimulus(input bit isD, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [3:0] ws,
                                 input int nBeats, input bit errLast, output int waited);
        if (isD) begin
            expQ.push_back('{1'b1, !we, cfgBase, 1'b1, errLast});
        end else begin
            for (int k = 0; k < nBeats; k++)
                expQ.push_back('{1'b0, 1'b1, cfgBase + 32'(k), (k == nBeats - 1), errLast && (k == nBeats - 1)});
        end
        @(posedge clk); #1;
        if (isD) begin
            dReq = 1'b1; dWe = we; dAddr = addr; dWdata = wd; dWstrb = ws;
        end else begin
            iReq = 1'b1; iAddr = addr;
        end
        waited = 0;
        @(negedge clk);
        while (!(isD ? dGnt : iGnt) && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) checkOutput("gnt_timeout", 32'(waited), 32'd0);
        @(posedge clk); #1;
        if (isD) dReq = 1'b0;
        else     iReq = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput(tag, 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // AXI slave model: samples requests on the falling edge, drives responses just after rising.
    initial begin
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        bvalid = 1'b0; bresp = 2'b00;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        forever begin
            @(negedge clk);
            wready = (cfgWDelay == 0);
            if (rstN && arvalid) begin
                int nb;
                nb = (cfgShortAt >= 0) ? cfgShortAt + 1 : int'(arlen) + 1;
                for (int k = 0; k < nb; k++) begin
                    @(posedge clk); #1;
                    if (!rstN) begin
                        rvalid = 1'b0; rlast = 1'b0;
                        break;
                    end
                    rvalid = 1'b1; rdata = cfgBase + 32'(k); rlast = (k == nb - 1); rresp = 2'b00;
                end
                @(posedge clk); #1;
                rvalid = 1'b0; rlast = 1'b0;
            end else if (rstN && awvalid) begin
                if (cfgWDelay > 0) begin
                    repeat (cfgWDelay) @(posedge clk);
                    #1 wready = 1'b1;
                end
                @(posedge clk); #1;
                wready = (cfgWDelay == 0); bvalid = 1'b1; bresp = cfgBresp;
                @(posedge clk); #1;
                bvalid = 1'b0; bresp = 2'b00;
            end
        end
    end

    // Monitor: every response pulse is matched against the head of the scoreboard.
    always @(negedge clk) begin
        expItem_t e;
        if (rstN) begin
            if (iGnt) gntLog.push_back(1'b0);
            if (dGnt) gntLog.push_back(1'b1);
            if (iGnt && dGnt) checkOutput("dual_gnt", 32'(dGnt), 32'(!iGnt));
            if (iRvalid || dDone) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_resp", 32'(expQ.size()), 32'd1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resp_side", 32'(dDone), 32'(e.isD));
                    if (iRvalid) begin
                        checkOutput("i_rdata", iRdata, e.data);
                        checkOutput("i_rlast", 32'(iRlast), 32'(e.last));
                        checkOutput("i_err", 32'(iErr), 32'(e.err));
                    end else begin
                        if (e.chkData) checkOutput("d_rdata", dRdata, e.data);
                        checkOutput("d_err", 32'(dErr), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", badChecks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int n;

        repeat (3) @(negedge clk);
        checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
        checkOutput("rst_awvalid", 32'(awvalid), 32'd0);
        checkOutput("rst_wvalid", 32'(wvalid), 32'd0);
        checkOutput("rst_rready", 32'(rready), 32'd0);
        checkOutput("rst_bready", 32'(bready), 32'd0);
        checkOutput("rst_irvalid", 32'(iRvalid), 32'd0);
        checkOutput("rst_ddone", 32'(dDone), 32'd0);
        checkOutput("rst_araddr", araddr, 32'd0);
        checkOutput("rst_arlen", 32'(arlen), 32'd0);
        checkOutput("rst_wlast", 32'(wlast), 32'd0);
        checkOutput("rst_wstrb", 32'(wstrb), 32'd0);
        checkOutput("rst_arsize", 32'(arsize), 32'd2);
        checkOutput("rst_awburst", 32'(awburst), 32'd1);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] D read");
        cfgBase = 32'hCAFE_F00D;
        applyStimulus(1'b1, 1'b0, 32'h0000_1003, '0, '0, 1, 1'b0, waited);
        checkOutput("dread_gnt_lat", 32'(waited), 32'd0);
        @(negedge clk);
        checkOutput("dread_arvalid", 32'(arvalid), 32'd1);
        checkOutput("dread_araddr", araddr, 32'h0000_1000);
        checkOutput("dread_arlen", 32'(arlen), 32'd0);
        checkOutput("dread_arburst", 32'(arburst), 32'd1);
        @(negedge clk);
        checkOutput("dread_rready", 32'(rready), 32'd1);
        checkOutput("dread_done_c2", 32'(dDone), 32'd0);
        @(negedge clk);
        checkOutput("dread_done_c3", 32'(dDone), 32'd1);
        waitDrain("dread_drain");

        $display("[TB] I refill");
        cfgBase = 32'h1111_0000;
        applyStimulus(1'b0, 1'b0, 32'h0000_2014, '0, '0, BEATS, 1'b0, waited);
        checkOutput("iref_gnt_lat", 32'(waited), 32'd0);
        @(negedge clk);
        checkOutput("iref_araddr", araddr, 32'h0000_2010);
        checkOutput("iref_arlen", 32'(arlen), 32'(BEATS - 1));
        @(negedge clk);
        checkOutput("iref_rvalid_c2", 32'(iRvalid), 32'd0);
        @(negedge clk);
        checkOutput("iref_rvalid_c3", 32'(iRvalid), 32'd1);
        waitDrain("iref_drain");

        $display("[TB] split write handshakes");
        cfgWDelay = 3; cfgBresp = 2'b10;
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h0000_3006, 32'hDEAD_BEEF, 4'b0011, 1, 1'b1, waited);
        checkOutput("wr_gnt_lat", 32'(waited), 32'd0);
        @(negedge clk);
        checkOutput("wr_c1_valids", {30'd0, awvalid, wvalid}, 32'b11);
        checkOutput("wr_awaddr", awaddr, 32'h0000_3004);
        checkOutput("wr_wstrb", 32'(wstrb), 32'b0011);
        checkOutput("wr_wdata", wdata, 32'hDEAD_BEEF);
        checkOutput("wr_wlast", 32'(wlast), 32'd1);
        @(negedge clk);
        checkOutput("wr_c2_valids", {30'd0, awvalid, wvalid}, 32'b01);
        @(negedge clk);
        checkOutput("wr_c3_valids", {30'd0, awvalid, wvalid}, 32'b01);
        @(negedge clk);
        checkOutput("wr_c4_valids", {30'd0, awvalid, wvalid}, 32'b01);
        @(negedge clk);
        checkOutput("wr_c5_wvalid", 32'(wvalid), 32'd0);
        checkOutput("wr_c5_bready", 32'(bready), 32'd1);
        waitDrain("wr_drain");
        cfgWDelay = 0; cfgBresp = 2'b00;

        $display("[TB] simultaneous requests");
        rstN = 1'b0;
        cfgBase = 32'h2222_0000;
        @(negedge clk);
        iReq = 1'b1; iAddr = 32'h0000_4000;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h0000_5008;
        @(negedge clk);
        checkOutput("rst_gnts_held", {30'd0, iGnt, dGnt}, 32'd0);
        gntLog.delete();
        expQ.push_back('{1'b1, 1'b1, cfgBase, 1'b1, 1'b0});
        for (int k = 0; k < BEATS; k++)
            expQ.push_back('{1'b0, 1'b1, cfgBase + 32'(k), (k == BEATS - 1), 1'b0});
        expQ.push_back('{1'b1, 1'b1, cfgBase, 1'b1, 1'b0});
        rstN = 1'b1;
        n = 0;
        while (gntLog.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        iReq = 1'b0; dReq = 1'b0;
        waitDrain("sim_drain");
        checkOutput("sim_gnt_count", 32'(gntLog.size()), 32'd3);
        if (gntLog.size() >= 3) begin
            checkOutput("sim_gnt0_is_d", 32'(gntLog[0]), 32'd1);
            checkOutput("sim_gnt1_is_d", 32'(gntLog[1]), 32'd0);
            checkOutput("sim_gnt2_is_d", 32'(gntLog[2]), 32'd1);
        end

        $display("[TB] short burst");
        cfgShortAt = 1;
        cfgBase = 32'h3333_0000;
        applyStimulus(1'b0, 1'b0, 32'h0000_6020, '0, '0, 2, 1'b1, waited);
        checkOutput("short_gnt_lat", 32'(waited), 32'd0);
        waitDrain("short_drain");
        checkOutput("short_idle", {30'd0, arvalid, rready}, 32'd0);
        cfgShortAt = -1;

        $display("[TB] reset mid-transaction");
        cfgBase = 32'h4444_0000;
        applyStimulus(1'b0, 1'b0, 32'h0000_7000, '0, '0, BEATS, 1'b0, waited);
        checkOutput("rstmid_gnt_lat", 32'(waited), 32'd0);
        n = 0;
        while (!iRvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rstmid_first_beat", 32'(iRvalid), 32'd1);
        @(posedge clk); #2;
        rstN = 1'b0;
        #1;
        checkOutput("rstmid_rready", 32'(rready), 32'd0);
        checkOutput("rstmid_arvalid", 32'(arvalid), 32'd0);
        checkOutput("rstmid_irvalid", 32'(iRvalid), 32'd0);
        expQ.delete();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        cfgBase = 32'h5555_AAAA;
        applyStimulus(1'b1, 1'b0, 32'h0000_8004, '0, '0, 1, 1'b0, waited);
        checkOutput("post_rst_gnt_lat", 32'(waited), 32'd0);
        @(negedge clk);
        checkOutput("post_rst_araddr", araddr, 32'h0000_8004);
        waitDrain("post_rst_drain");

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
